// File: rtl/core_pkg.sv
// core_pkg: shared constants for the 5-stage core hazard logic.
//  - FWD_RF / FWD_M / FWD_W : E-stage forward-select encodings
//  - hz_state_e             : memory-wait FSM state encoding (2-bit)
package core_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from aluoutM
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from resultW

  typedef enum logic [1:0] {
    HZ_IDLE    = 2'b00,
    HZ_MEMWAIT = 2'b01,
    HZ_TIMEOUT = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_mem_fsm.sv
// hazard_mem_fsm: tracks a multi-cycle data-memory access in the M stage.
//  clk, reset    : clock, synchronous active-high reset
//  memreqM       : load/store active in Memory
//  memreadyM     : memory completes the access this cycle
//  state_o       : current FSM state (IDLE / MEMWAIT / TIMEOUT)
//  memerr        : sticky timeout flag, cleared only by reset
module hazard_mem_fsm
  import core_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      memreqM,
  input  logic      memreadyM,
  output hz_state_e state_o,
  output logic      memerr
);

  localparam int WC_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_WAIT_MAX);

  hz_state_e       state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            memerr_q, memerr_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    memerr_d   = memerr_q;
    case (state_q)
      HZ_IDLE: begin
        // An access that completes in its first cycle never enters MEMWAIT.
        if (memreqM && !memreadyM) begin
          state_d    = HZ_MEMWAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      HZ_MEMWAIT: begin
        if (memreadyM) begin
          state_d    = HZ_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_MAX) begin
          state_d  = HZ_TIMEOUT;
          memerr_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      HZ_TIMEOUT: begin
        // Terminal until reset: the pipeline stays frozen.
        memerr_d = 1'b1;
      end
      default: begin
        state_d    = HZ_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HZ_IDLE;
      wait_cnt_q <= '0;
      memerr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      memerr_q   <= memerr_d;
    end
  end

  assign state_o = state_q;
  assign memerr  = memerr_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: stall/flush/forward controller for the F/D/E/M/W core.
//  Inputs : decode/execute source regs, per-stage dest regs and write/load
//           flags, branch info from D, memory request/ready handshake in M.
//  Outputs: stallF/D/E/M, flushD/E/W, E-stage forward selects (fwdAE/BE),
//           D-stage branch forward selects (fwdAD/BD), sticky memerr and a
//           saturating count of cycles with stallF asserted.
//  Priority: reset > memory stall > data-hazard stall > branch flush.
module hazard_unit_mc
  import core_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int FWD_EN       = 1,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  rs1D,
  input  logic [RA_W-1:0]  rs2D,
  input  logic [RA_W-1:0]  rs1E,
  input  logic [RA_W-1:0]  rs2E,
  input  logic [RA_W-1:0]  rdE,
  input  logic [RA_W-1:0]  rdM,
  input  logic [RA_W-1:0]  rdW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             pcsrcD,
  input  logic             memreqM,
  input  logic             memreadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       fwdAE,
  output logic [1:0]       fwdBE,
  output logic             fwdAD,
  output logic             fwdBD,
  output logic             memerr,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_state_e mem_state;

  hazard_mem_fsm #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_mem_fsm (
    .clk      (clk),
    .reset    (reset),
    .memreqM  (memreqM),
    .memreadyM(memreadyM),
    .state_o  (mem_state),
    .memerr   (memerr)
  );

  // Register 0 is hardwired, so a zero destination never creates a hazard.
  logic e_live, m_live, w_live;
  logic e_hits_d, m_hits_d;
  logic lwstall, brstall, rawstall, dstall, memstall;
  logic [1:0] fwd_ae, fwd_be;

  always_comb begin
    e_live   = (rdE != '0);
    m_live   = regwriteM && (rdM != '0);
    w_live   = regwriteW && (rdW != '0);
    e_hits_d = e_live && ((rdE == rs1D) || (rdE == rs2D));
    m_hits_d = (rdM != '0) && ((rdM == rs1D) || (rdM == rs2D));

    // M is the younger producer, so it wins over W.
    fwd_ae = FWD_RF;
    if (m_live && (rdM == rs1E))      fwd_ae = FWD_M;
    else if (w_live && (rdW == rs1E)) fwd_ae = FWD_W;
    fwd_be = FWD_RF;
    if (m_live && (rdM == rs2E))      fwd_be = FWD_M;
    else if (w_live && (rdW == rs2E)) fwd_be = FWD_W;

    lwstall  = memtoregE && e_hits_d;
    // Branches resolve in D: an E-stage result or an M-stage load is not
    // yet available on the D-stage compare path.
    brstall  = branchD && ((regwriteE && e_hits_d) || (memtoregM && m_hits_d));
    // Without forwarding, anything still in E or M must drain; W is covered
    // by the write-first register file.
    rawstall = (regwriteE && e_hits_d) || (regwriteM && m_hits_d);

    // The cycle memreadyM rises releases the pipeline, matching the
    // first-cycle-hit case in IDLE.
    memstall = ((mem_state == HZ_IDLE) && memreqM && !memreadyM) ||
               ((mem_state == HZ_MEMWAIT) && !memreadyM) ||
               (mem_state == HZ_TIMEOUT);
  end

  always_comb begin
    dstall = (FWD_EN != 0) ? (lwstall || brstall) : rawstall;

    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b1;
    flushE = 1'b1;
    flushW = 1'b1;
    fwdAE  = FWD_RF;
    fwdBE  = FWD_RF;
    fwdAD  = 1'b0;
    fwdBD  = 1'b0;

    if (!reset) begin
      if (FWD_EN != 0) begin
        fwdAE = fwd_ae;
        fwdBE = fwd_be;
        fwdAD = m_live && (rdM == rs1D);
        fwdBD = m_live && (rdM == rs2D);
      end
      if (memstall) begin
        // Whole front of the pipe freezes; E is held, not bubbled.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b1;
      end else begin
        stallF = dstall;
        stallD = dstall;
        flushE = dstall;
        flushD = pcsrcD && !dstall;
        flushW = 1'b0;
      end
    end
  end

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, pcsrcD, memreqM, memreadyM;

  // dut0: forwarding on, short timeout. dut1: forwarding off, 2-bit counter.
  logic       sF0, sD0, sE0, sM0, fD0, fE0, fW0, aD0, bD0, err0;
  logic [1:0] aE0, bE0;
  logic [15:0] cnt0;
  logic       sF1, sD1, sE1, sM1, fD1, fE1, fW1, aD1, bD1, err1;
  logic [1:0] aE1, bE1;
  logic [1:0] cnt1;

  hazard_unit_mc #(.RA_W(5), .FWD_EN(1), .MEM_WAIT_MAX(4), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .pcsrcD(pcsrcD), .memreqM(memreqM), .memreadyM(memreadyM),
    .stallF(sF0), .stallD(sD0), .stallE(sE0), .stallM(sM0), .flushD(fD0),
    .flushE(fE0), .flushW(fW0), .fwdAE(aE0), .fwdBE(bE0), .fwdAD(aD0), .fwdBD(bD0),
    .memerr(err0), .stall_cnt(cnt0));

  hazard_unit_mc #(.RA_W(5), .FWD_EN(0), .MEM_WAIT_MAX(15), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .pcsrcD(pcsrcD), .memreqM(memreqM), .memreadyM(memreadyM),
    .stallF(sF1), .stallD(sD1), .stallE(sE1), .stallM(sM1), .flushD(fD1),
    .flushE(fE1), .flushW(fW1), .fwdAE(aE1), .fwdBE(bE1), .fwdAD(aD1), .fwdBD(bD1),
    .memerr(err1), .stall_cnt(cnt1));

  // {stallF,stallD,stallE,stallM, flushD,flushE,flushW, fwdAE, fwdBE, fwdAD,fwdBD}
  function automatic logic [12:0] out0();
    return {sF0, sD0, sE0, sM0, fD0, fE0, fW0, aE0, bE0, aD0, bD0};
  endfunction
  function automatic logic [12:0] out1();
    return {sF1, sD1, sE1, sM1, fD1, fE1, fW1, aE1, bE1, aD1, bD1};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [2:0]  rw;   // {regwriteE, regwriteM, regwriteW}
    logic [1:0]  mt;   // {memtoregE, memtoregM}
    logic        br, pc;
    logic [12:0] exp0; // dut0 expected outputs
    logic        raw;  // dut1 expected RAW stall
  } vec_t;

  vec_t vecs[13];

  task automatic setv(input int i, input logic [4:0] a1D, a2D, a1E, a2E, dE, dM, dW,
                      input logic [2:0] rw, input logic [1:0] mt, input logic br, pc,
                      input logic [12:0] e0, input logic raw);
    vecs[i].rs1D = a1D; vecs[i].rs2D = a2D; vecs[i].rs1E = a1E; vecs[i].rs2E = a2E;
    vecs[i].rdE = dE; vecs[i].rdM = dM; vecs[i].rdW = dW;
    vecs[i].rw = rw; vecs[i].mt = mt; vecs[i].br = br; vecs[i].pc = pc;
    vecs[i].exp0 = e0; vecs[i].raw = raw;
  endtask

  task automatic clear_in();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
    branchD = 0; pcsrcD = 0; memreqM = 0; memreadyM = 0;
  endtask

  task automatic drive(input vec_t v);
    rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
    rdE = v.rdE; rdM = v.rdM; rdW = v.rdW;
    {regwriteE, regwriteM, regwriteW} = v.rw;
    {memtoregE, memtoregM} = v.mt;
    branchD = v.br; pcsrcD = v.pc;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] e1;
    // idle
    setv(0,  0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 13'b0000_000_00_00_00, 0);
    // lw x5 in E, rs1D=5
    setv(1,  5, 0, 0, 0, 5, 0, 0, 3'b100, 2'b10, 0, 0, 13'b1100_010_00_00_00, 1);
    // M and W both write x3: M wins
    setv(2,  0, 0, 3, 0, 0, 3, 3, 3'b011, 2'b00, 0, 0, 13'b0000_000_10_00_00, 0);
    // only W writes x3
    setv(3,  0, 0, 3, 0, 0, 3, 3, 3'b001, 2'b00, 0, 0, 13'b0000_000_01_00_00, 0);
    // x0 everywhere: no forward, no stall
    setv(4,  0, 0, 0, 0, 0, 0, 0, 3'b111, 2'b00, 0, 0, 13'b0000_000_00_00_00, 0);
    // beq with ALU producer in E
    setv(5,  0, 7, 0, 0, 7, 0, 0, 3'b100, 2'b00, 1, 0, 13'b1100_010_00_00_00, 1);
    // producer moved to M: branch forward + taken flush
    setv(6,  0, 7, 0, 0, 0, 7, 0, 3'b010, 2'b00, 1, 1, 13'b0000_100_00_00_01, 1);
    // branch on load in M: stall beats flushD
    setv(7,  9, 0, 0, 0, 0, 9, 0, 3'b010, 2'b01, 1, 1, 13'b1100_010_00_00_10, 0);
    // both E operands from M
    setv(8,  0, 0, 6, 6, 0, 6, 6, 3'b011, 2'b00, 0, 0, 13'b0000_000_10_10_00, 0);
    // load to x0 never stalls
    setv(9,  0, 0, 0, 0, 0, 0, 0, 3'b100, 2'b10, 0, 0, 13'b0000_000_00_00_00, 0);
    // plain taken branch
    setv(10, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 1, 1, 13'b0000_100_00_00_00, 0);
    // lw match on rs2D, plus B operand from W
    setv(11, 0, 12, 0, 12, 12, 0, 12, 3'b101, 2'b10, 0, 0, 13'b1100_010_00_01_00, 1);
    // M writes a different reg, W matches
    setv(12, 0, 0, 3, 0, 0, 4, 3, 3'b011, 2'b00, 0, 0, 13'b0000_000_01_00_00, 0);
    // vec 7: rawstall also true for dut1 (regwriteM, rdM=9 == rs1D)
    vecs[7].raw = 1;

    // reset state, with inputs that would otherwise forward
    reset = 1'b1;
    clear_in();
    drive(vecs[2]);
    rs1D = 3; memreqM = 1;
    @(posedge clk); @(posedge clk); #1;
    check("reset_out0", out0(), 13'b0000_111_00_00_00);
    check("reset_out1", out1(), 13'b0000_111_00_00_00);
    check("reset_cnt_err", {cnt0, err0, err1}, 18'd0);
    #1 reset = 1'b0;
    clear_in();

    // table: combinational hazard/forward decisions in IDLE
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      #3;
      check($sformatf("vec%0d_dut0", i), out0(), vecs[i].exp0);
      e1 = {vecs[i].raw, vecs[i].raw, 2'b00, vecs[i].pc & ~vecs[i].raw, vecs[i].raw, 1'b0, 6'b0};
      check($sformatf("vec%0d_dut1", i), out1(), e1);
      step();
    end

    // lw stall lasts one cycle once the load leaves E
    do_reset();
    drive(vecs[1]);
    #3 check("lw_stall", {sF0, sD0, fE0}, 3'b111);
    step();
    clear_in(); rdM = 5; regwriteM = 1; memtoregM = 1; rs1E = 5;
    #3 check("lw_release", {sF0, sD0, fE0, aE0}, {3'b000, 2'b10});

    // memory wait: 3 stall cycles, then ready
    do_reset();
    memreqM = 1; memreadyM = 0;
    #3 check("mw_c1", out0(), 13'b1111_001_00_00_00);
    step();
    rdE = 5; rs1D = 5; regwriteE = 1; memtoregE = 1;  // dstall masked by memstall
    #3 check("mw_c2_mask", out0(), 13'b1111_001_00_00_00);
    step();
    rdE = 0; rs1D = 0; regwriteE = 0; memtoregE = 0;
    #3 check("mw_c3", out0(), 13'b1111_001_00_00_00);
    step();
    memreadyM = 1;
    #3 check("mw_ready", out0(), 13'b0000_000_00_00_00);
    step();
    memreqM = 0; memreadyM = 0;
    #3 check("mw_after", {sF0, fW0, err0}, 3'b000);
    check("mw_cnt", cnt0, 16'd3);

    // hit in first cycle: no stall
    memreqM = 1; memreadyM = 1;
    #3 check("mw_hit", {sF0, sM0, fW0}, 3'b000);
    step();
    memreqM = 0; memreadyM = 0;

    // timeout after 4 MEMWAIT cycles
    do_reset();
    memreqM = 1; memreadyM = 0;
    #3 check("to_c0", {sF0, sM0, err0}, 3'b110);
    for (int i = 1; i <= 5; i++) begin
      step();
      #3 check($sformatf("to_err%0d", i), {sF0, sE0, err0}, {2'b11, (i == 5) ? 1'b1 : 1'b0});
    end
    memreqM = 0; memreadyM = 1;
    step();
    #3 check("to_hold", {out0(), err0}, {13'b1111_001_00_00_00, 1'b1});
    reset = 1'b1;
    #1 check("to_in_reset", out0(), 13'b0000_111_00_00_00);
    @(posedge clk); #1 reset = 1'b0;
    memreadyM = 0;
    #3 check("to_cleared", {sF0, fW0, err0, cnt0}, 19'd0);

    // FWD_EN=0: RAW on M stalls; 2-bit counter saturates
    do_reset();
    regwriteM = 1; rdM = 4; rs2D = 4;
    #3 check("nofwd_dut0", {sF0, bD0}, 2'b01);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("nofwd_st%0d", i), {sF1, sD1, fE1, bD1, aE1, bE1}, 8'b1110_0000);
      check($sformatf("nofwd_cnt%0d", i), cnt1, (i - 1 > 3) ? 2'd3 : 2'(i - 1));
      step();
      #3;
    end
    check("nofwd_sat", cnt1, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
